// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL lock controller: state encoding, timer width
// and a saturating retry-counter helper.
package pll_ctrl_pkg;

  localparam int TIMER_W = 16;
  localparam int RETRY_W = 4;

  localparam logic [2:0] S_RST  = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_STAB = 3'd2;
  localparam logic [2:0] S_GDLY = 3'd3;
  localparam logic [2:0] S_RUN  = 3'd4;
  localparam logic [2:0] S_FAIL = 3'd5;

  typedef enum logic [2:0] {
    ST_RST  = S_RST,
    ST_WAIT = S_WAIT,
    ST_STAB = S_STAB,
    ST_GDLY = S_GDLY,
    ST_RUN  = S_RUN,
    ST_FAIL = S_FAIL
  } state_e;

  typedef logic [TIMER_W-1:0] timer_t;
  typedef logic [RETRY_W-1:0] retry_t;

  function automatic retry_t sat_inc(input retry_t cnt, input retry_t max_val);
    return (cnt >= max_val) ? max_val : retry_t'(cnt + retry_t'(1));
  endfunction

endpackage

// File: rtl/pll_lock_ctrl_if.sv
// Control/status bundle between the PLL lock controller and its environment.
interface pll_lock_ctrl_if;
  import pll_ctrl_pkg::*;

  // restart is a one-cycle strobe sampled on clk; pll_lock is a raw asynchronous
  // level. Every output is a registered level, so there is no valid/ready pairing.
  logic       restart;
  logic       pll_lock;
  logic       pll_rst;
  logic       clkout0_gate;
  logic       ready;
  logic       fail;
  logic       lock_lost;
  retry_t     retry_cnt;
  logic [2:0] state;

  modport master (
    input  restart,
    input  pll_lock,
    output pll_rst,
    output clkout0_gate,
    output ready,
    output fail,
    output lock_lost,
    output retry_cnt,
    output state
  );

  modport slave (
    output restart,
    output pll_lock,
    input  pll_rst,
    input  clkout0_gate,
    input  ready,
    input  fail,
    input  lock_lost,
    input  retry_cnt,
    input  state
  );

endinterface

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock flag into clk.
module pll_lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL lock sequencer: pulses the PLL reset, waits for a stable lock, then opens
// the clkout0 gate; retries on timeout and gives up after MAX_RETRY failures.
module pll_lock_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 50000,
  parameter int unsigned LOCK_STABLE  = 256,
  parameter int unsigned GATE_DELAY   = 8,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  pll_lock_ctrl_if.master bus
);

  localparam timer_t RST_LAST  = timer_t'(RST_CYCLES - 1);
  localparam timer_t TO_LAST   = timer_t'(LOCK_TIMEOUT - 1);
  localparam timer_t STAB_LAST = timer_t'(LOCK_STABLE - 1);
  localparam timer_t GDLY_LAST = timer_t'(GATE_DELAY - 1);
  localparam retry_t RETRY_MAX = retry_t'(MAX_RETRY);

  logic   lock_s;
  state_e state_q, state_d;
  timer_t timer_q, timer_d;
  retry_t retry_q, retry_d;
  logic   lock_lost_q, lock_lost_d;
  logic   pll_rst_q, pll_rst_d;
  logic   gate_q, gate_d;
  logic   fail_q, fail_d;
  logic   timeout_ev;
  retry_t retry_inc;

  pll_lock_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (bus.pll_lock),
    .sync_out (lock_s)
  );

  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    lock_lost_d = lock_lost_q;
    timeout_ev  = 1'b0;
    retry_inc   = sat_inc(retry_q, RETRY_MAX);

    unique case (state_q)
      ST_RST: begin
        if (timer_q == RST_LAST) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (lock_s)                   state_d    = ST_STAB;
        else if (timer_q == TO_LAST)  timeout_ev = 1'b1;
      end
      ST_STAB: begin
        if (!lock_s)                   state_d = ST_WAIT;
        else if (timer_q == STAB_LAST) state_d = ST_GDLY;
      end
      ST_GDLY: begin
        if (!lock_s)                   timeout_ev = 1'b1;
        else if (timer_q == GDLY_LAST) state_d    = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d     = ST_RST;
          lock_lost_d = 1'b1;
          retry_d     = retry_inc;
        end
      end
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_RST;
    endcase

    if (timeout_ev) begin
      retry_d = retry_inc;
      state_d = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_RST;
    end

    // restart overrides whatever the lock or timer decided this cycle
    if (bus.restart) begin
      state_d     = ST_RST;
      retry_d     = '0;
      lock_lost_d = 1'b0;
    end
  end

  // Timer restarts on every state entry, including a restart re-entering RST.
  always_comb begin
    if (bus.restart || (state_d != state_q)) timer_d = '0;
    else if (timer_q == '1)                  timer_d = timer_q;
    else                                     timer_d = timer_t'(timer_q + timer_t'(1));
  end

  always_comb begin
    pll_rst_d = (state_d == ST_RST) || (state_d == ST_FAIL);
    gate_d    = (state_d == ST_RUN);
    fail_d    = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RST;
      timer_q     <= '0;
      retry_q     <= '0;
      lock_lost_q <= 1'b0;
      pll_rst_q   <= 1'b1;
      gate_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      lock_lost_q <= lock_lost_d;
      pll_rst_q   <= pll_rst_d;
      gate_q      <= gate_d;
      fail_q      <= fail_d;
    end
  end

  assign bus.pll_rst      = pll_rst_q;
  assign bus.clkout0_gate = gate_q;
  assign bus.ready        = gate_q;
  assign bus.fail         = fail_q;
  assign bus.lock_lost    = lock_lost_q;
  assign bus.retry_cnt    = retry_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl: power-on, lock, lock loss, timeouts to FAIL,
// restart, STAB glitch and asynchronous reset in GDLY.
module tb_pll_lock_ctrl;
  import pll_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt  = 0;
  int   fail_cnt  = 0;
  int   check_cnt = 0;
  int   n;

  pll_lock_ctrl_if bus ();

  pll_lock_ctrl #(
    .RST_CYCLES   (16),
    .LOCK_TIMEOUT (1000),
    .LOCK_STABLE  (32),
    .GATE_DELAY   (8),
    .MAX_RETRY    (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // driver / measurement tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},     32'(bus.state),        32'd0);
    check({tag, "_pll_rst"},   32'(bus.pll_rst),      32'd1);
    check({tag, "_gate"},      32'(bus.clkout0_gate), 32'd0);
    check({tag, "_ready"},     32'(bus.ready),        32'd0);
    check({tag, "_fail"},      32'(bus.fail),         32'd0);
    check({tag, "_lock_lost"}, 32'(bus.lock_lost),    32'd0);
    check({tag, "_retry"},     32'(bus.retry_cnt),    32'd0);
  endtask

  task automatic count_rst_high(output int cnt);
    cnt = 0;
    while (bus.pll_rst === 1'b1 && cnt < 100) begin step(); cnt++; end
  endtask

  task automatic count_rst_low(output int cnt);
    cnt = 0;
    while (bus.pll_rst !== 1'b1 && cnt < 2000) begin step(); cnt++; end
  endtask

  task automatic count_until_ready(output int cnt);
    cnt = 0;
    while (bus.ready !== 1'b1 && cnt < 200) begin step(); cnt++; end
  endtask

  task automatic count_until_gate_low(output int cnt);
    cnt = 0;
    while (bus.clkout0_gate !== 1'b0 && cnt < 20) begin step(); cnt++; end
  endtask

  task automatic wait_state(input logic [2:0] s, input int limit, output int cnt);
    cnt = 0;
    while (bus.state !== s && cnt < limit) begin step(); cnt++; end
  endtask

  // directed sequence
  initial begin
    bus.restart  = 1'b0;
    bus.pll_lock = 1'b0;
    rst_n        = 1'b0;
    repeat (3) step();
    check_reset_values("por");

    // normal lock: 16-cycle pll_rst, lock 100 cycles later, ready 43 edges on
    rst_n = 1'b1;
    count_rst_high(n);
    check("por_rst_pulse", 32'(n), 32'd16);
    check("por_wait_state", 32'(bus.state), 32'd1);
    repeat (99) step();
    bus.pll_lock = 1'b1;
    count_until_ready(n);
    check("lock_to_ready", 32'(n), 32'd43);
    check("run_gate", 32'(bus.clkout0_gate), 32'd1);
    check("run_state", 32'(bus.state), 32'd4);
    check("run_retry", 32'(bus.retry_cnt), 32'd0);
    check("run_lock_lost", 32'(bus.lock_lost), 32'd0);

    // lock lost in RUN
    bus.pll_lock = 1'b0;
    count_until_gate_low(n);
    check("loss_gate_latency", 32'(n), 32'd3);
    check("loss_ready", 32'(bus.ready), 32'd0);
    check("loss_lock_lost", 32'(bus.lock_lost), 32'd1);
    check("loss_retry", 32'(bus.retry_cnt), 32'd1);
    check("loss_state", 32'(bus.state), 32'd0);
    count_rst_high(n);
    check("loss_rst_pulse", 32'(n), 32'd16);
    bus.pll_lock = 1'b1;
    count_until_ready(n);
    check("relock_to_ready", 32'(n), 32'd43);
    check("relock_lock_lost", 32'(bus.lock_lost), 32'd1);
    check("relock_retry", 32'(bus.retry_cnt), 32'd1);

    // restart, then lock held low: three timeouts into FAIL
    bus.pll_lock = 1'b0;
    bus.restart  = 1'b1;
    step();
    bus.restart  = 1'b0;
    check_reset_values("restart_run");
    for (int k = 1; k <= 3; k++) begin
      count_rst_high(n);
      check($sformatf("to%0d_rst_pulse", k), 32'(n), 32'd16);
      count_rst_low(n);
      check($sformatf("to%0d_wait_len", k), 32'(n), 32'd1000);
      check($sformatf("to%0d_retry", k), 32'(bus.retry_cnt), 32'(k));
    end
    check("fail_state", 32'(bus.state), 32'd5);
    check("fail_flag", 32'(bus.fail), 32'd1);
    repeat (50) step();
    check("fail_hold_state", 32'(bus.state), 32'd5);
    check("fail_hold_pll_rst", 32'(bus.pll_rst), 32'd1);
    check("fail_hold_retry", 32'(bus.retry_cnt), 32'd3);

    // restart out of FAIL
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
    check_reset_values("restart_fail");
    count_rst_high(n);
    check("restart_fail_rst_pulse", 32'(n), 32'd16);

    // one-cycle lock glitch during STAB
    repeat (10) step();
    bus.pll_lock = 1'b1;
    wait_state(3'd2, 20, n);
    check("glitch_enter_stab", 32'(bus.state), 32'd2);
    repeat (20) step();
    bus.pll_lock = 1'b0;
    step();
    bus.pll_lock = 1'b1;
    step();
    step();
    check("glitch_back_to_wait", 32'(bus.state), 32'd1);
    check("glitch_retry_wait", 32'(bus.retry_cnt), 32'd0);
    count_until_ready(n);
    check("glitch_to_ready", 32'(n), 32'd41);
    check("glitch_retry_run", 32'(bus.retry_cnt), 32'd0);

    // asynchronous reset in the middle of GDLY
    bus.pll_lock = 1'b0;
    wait_state(3'd0, 10, n);
    check("pre_rst_state", 32'(bus.state), 32'd0);
    bus.pll_lock = 1'b1;
    wait_state(3'd3, 100, n);
    check("pre_rst_gdly", 32'(bus.state), 32'd3);
    check("pre_rst_retry", 32'(bus.retry_cnt), 32'd1);
    check("pre_rst_lock_lost", 32'(bus.lock_lost), 32'd1);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    repeat (2) step();
    rst_n = 1'b1;
    count_rst_high(n);
    check("post_rst_pulse", 32'(n), 32'd16);
    count_until_ready(n);
    check("post_rst_to_ready", 32'(n), 32'd41);
    check("post_rst_lock_lost", 32'(bus.lock_lost), 32'd0);

    // final report
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/pll_lock_ctrl.md
PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 16: cycles pll_rst is held high per attempt; range 1..65535.
REQ-002 Parameter LOCK_TIMEOUT, default 50000: cycles allowed from pll_rst release to a stable lock (1 ms at 50 MHz); range 1..65535.
REQ-003 Parameter LOCK_STABLE, default 256: consecutive synchronized-lock-high cycles required before lock is accepted; range 1..65535.
REQ-004 Parameter GATE_DELAY, default 8: cycles from accepted lock to clkout0_gate assertion; range 1..65535.
REQ-005 Parameter MAX_RETRY, default 3: failed attempts tolerated before FAIL; range 1..15.
REQ-006 clk  in  1  free-running PLL reference clock (50 MHz); sole clock of the block.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 restart  in  1  synchronous single-cycle request to restart the whole sequence.
REQ-009 pll_lock  in  1  PLL lock flag, asynchronous to clk.
REQ-010 pll_rst  out  1  PLL reset, active-high, registered.
REQ-011 clkout0_gate  out  1  clkout0 gate enable (1 = clock passes), registered.
REQ-012 ready  out  1  PLL locked and gated clock running.
REQ-013 fail  out  1  retry budget exhausted.
REQ-014 lock_lost  out  1  sticky: lock dropped while in RUN.
REQ-015 retry_cnt  out  4  failed attempts in the current sequence.
REQ-016 state  out  3  current FSM state encoding, for debug.

Function
REQ-017 pll_lock SHALL pass through a 2-flop synchronizer (lock_s); all decisions use lock_s only.
REQ-018 FSM states SHALL be RST=0, WAIT=1, STAB=2, GDLY=3, RUN=4, FAIL=5; one shared 16-bit timer, cleared on every state entry.
REQ-019 RST: pll_rst=1; after RST_CYCLES cycles -> WAIT.
REQ-020 WAIT: pll_rst=0; lock_s=1 -> STAB; timer reaching LOCK_TIMEOUT with lock_s=0 -> timeout event.
REQ-021 STAB: lock_s=0 -> WAIT with timer cleared; LOCK_STABLE consecutive lock_s=1 cycles -> GDLY.
REQ-022 GDLY: after GATE_DELAY cycles -> RUN; lock_s=0 during GDLY counts as a timeout event.
REQ-023 RUN: clkout0_gate=1, ready=1; lock_s=0 -> clkout0_gate and ready deassert on the next edge, lock_lost set, retry_cnt incremented, -> RST.
REQ-024 Timeout event: retry_cnt+1; if new value == MAX_RETRY -> FAIL, else -> RST.
REQ-025 FAIL: pll_rst=1, fail=1, clkout0_gate=0; held until restart or rst_n.
REQ-026 restart=1 in any state SHALL, on the next edge, clear retry_cnt, lock_lost, fail, ready, clkout0_gate and enter RST; restart takes priority over any simultaneous lock or timer event.
REQ-027 clkout0_gate SHALL be 1 only in RUN; ready == clkout0_gate at all times.
REQ-028 retry_cnt SHALL saturate at MAX_RETRY and never wrap.
REQ-029 Lock success in RUN SHALL NOT clear retry_cnt; only restart or rst_n does.

Reset
REQ-030 rst_n low SHALL asynchronously force state=RST, timer=0, pll_rst=1, clkout0_gate=0, ready=0, fail=0, lock_lost=0, retry_cnt=0, synchronizer flops=0.
REQ-031 After rst_n deasserts, the sequence starts at RST and counts a full RST_CYCLES; an rst_n assertion mid-sequence aborts it immediately with the values above.

Structure
REQ-032 State encoding localparams and the 16-bit timer width SHALL live in shared package pll_ctrl_pkg.
REQ-033 The 2-flop synchronizer SHALL be sub-module pll_lock_sync; everything else stays in pll_lock_ctrl.

Verification (RST_CYCLES=16, LOCK_TIMEOUT=1000, LOCK_STABLE=32, GATE_DELAY=8, MAX_RETRY=3)
REQ-034 pll_lock rises 100 cycles after pll_rst falls and stays high -> pll_rst high exactly 16 cycles; clkout0_gate=1 and ready=1 exactly 2+32+8 cycles after the lock edge (±1 for synchronizer phase).
REQ-035 pll_lock held low -> 3 timeouts, each preceded by a 16-cycle pll_rst pulse; after the third, fail=1, retry_cnt=3, pll_rst stays high.
REQ-036 pll_lock glitches low for 1 cycle at STAB count 20 -> returns to WAIT, stable count restarts, ready delayed accordingly, retry_cnt unchanged.
REQ-037 pll_lock drops in RUN -> clkout0_gate=0 within 3 cycles, lock_lost=1, retry_cnt=1, new 16-cycle pll_rst pulse; relock -> ready=1 with lock_lost still 1.
REQ-038 restart pulse in FAIL, and separately rst_n asserted mid-GDLY -> all outputs at reset values, state=RST, full sequence repeats.
